miss_handler: RTL

MISS_HANDLER -- requirements
Module: miss_handler

---
 rtl/cache_pkg.sv | 21 ++
 rtl/miss_handler.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: refill FSM states, AXI encodings and the address-split helper.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    TAG
  } refill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int offset_width(input int addr_w, input int tag_w, input int set_w);
    return addr_w - tag_w - set_w;
  endfunction

  // Line-offset width for the default 10-bit address / 3-bit tag / 3-bit set geometry.
  localparam int OFFSET_WIDTH = offset_width(10, 3, 3);

endpackage

// File: rtl/miss_handler.sv
// Cache miss handler: issues one AXI INCR line read, streams beats into the data array, then writes the tag.
// Optional MISS_HANDLER_RESP_CHECK_EN flags bad RRESP/RLAST and writes the refilled tag invalid.
module miss_handler
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 3,
  parameter int SET_WIDTH  = 3,
  parameter int NUM_WAYS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_lookup_valid,
  input  logic                     i_hit,
  input  logic [NUM_WAYS-1:0]      i_way_select,
  input  logic [TAG_WIDTH-1:0]     i_addr_tag,
  input  logic [SET_WIDTH-1:0]     i_addr_set,
  output logic                     o_busy,
  output logic [ADDR_WIDTH-1:0]    o_araddr,
  output logic [7:0]               o_arlen,
  output logic [1:0]               o_arburst,
  output logic                     o_arvalid,
  input  logic                     i_arready,
  input  logic [DATA_WIDTH-1:0]    i_rdata,
  input  logic [1:0]               i_rresp,
  input  logic                     i_rlast,
  input  logic                     i_rvalid,
  output logic                     o_rready,
  output logic                     o_data_we,
  output logic [NUM_WAYS-1:0]      o_data_way,
  output logic [SET_WIDTH-1:0]     o_data_set,
  output logic [$clog2(BEATS)-1:0] o_data_beat,
  output logic [DATA_WIDTH-1:0]    o_data_wdata,
  output logic                     o_tag_we,
  output logic [NUM_WAYS-1:0]      o_tag_way,
  output logic [SET_WIDTH-1:0]     o_tag_set,
  output logic [TAG_WIDTH:0]       o_tag_wdata,
  output logic                     o_refill_done,
  output logic                     o_refill_error
);

  localparam int OFF_W  = offset_width(ADDR_WIDTH, TAG_WIDTH, SET_WIDTH);
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  refill_state_t         state;
  logic [BEAT_W-1:0]     beat_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [SET_WIDTH-1:0]  set_q;
  logic [NUM_WAYS-1:0]   way_q;
  logic                  err_q;
  logic                  err_set;
  logic                  run;

  // Outputs are forced low while reset is held, not just after the edge that applies it.
  assign run = !reset;

`ifdef MISS_HANDLER_RESP_CHECK_EN
  assign err_set = (i_rresp != AXI_RESP_OKAY) || (i_rlast != (beat_q == LAST_BEAT));
`else
  logic unused_resp;
  assign unused_resp = ^{i_rresp, i_rlast};
  assign err_set     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
    if (reset) begin
      state  <= IDLE;
      beat_q <= '0;
      tag_q  <= '0;
      set_q  <= '0;
      way_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_lookup_valid && !i_hit) begin
            tag_q <= i_addr_tag;
            set_q <= i_addr_set;
            way_q <= i_way_select;
            err_q <= 1'b0;
            state <= AR;
          end
        end
        AR: begin
          if (i_arready) begin
            beat_q <= '0;
            state  <= R;
          end
        end
        R: begin
          if (i_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (err_set) err_q <= 1'b1;
            if (beat_q == LAST_BEAT) state <= TAG;
          end
        end
        TAG: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // AR payload comes from latched registers, so it holds steady across any ARREADY stall.
  assign o_busy    = run && (state != IDLE);
  assign o_arvalid = run && (state == AR);
  assign o_araddr  = {tag_q, set_q, {OFF_W{1'b0}}};
  assign o_arlen   = 8'(BEATS - 1);
  assign o_arburst = AXI_BURST_INCR;

  assign o_rready     = run && (state == R);
  assign o_data_we    = run && (state == R) && i_rvalid;
  assign o_data_way   = way_q;
  assign o_data_set   = set_q;
  assign o_data_beat  = beat_q;
  assign o_data_wdata = i_rdata;

  assign o_tag_we      = run && (state == TAG);
  assign o_tag_way     = way_q;
  assign o_tag_set     = set_q;
  assign o_refill_done = run && (state == TAG);

`ifdef MISS_HANDLER_RESP_CHECK_EN
  assign o_tag_wdata    = {!err_q, tag_q};
  assign o_refill_error = run && (state == TAG) && err_q;
`else
  assign o_tag_wdata    = {1'b1, tag_q};
  assign o_refill_error = 1'b0;
`endif

endmodule
